uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
Byte buffer and launch controller sitting directly upstream of the UART transmitter. Accepts bytes from the host side into a circular FIFO, presents one byte at a time to the transmitter with a single-cycle tx_start pulse, then waits for the transmitter's tx_done_tick before launching the next byte. Decouples host write bursts from serial line rate.

Parameters:
DBIT, 8, data byte width; matches transmitter data width.
ADDR_W, 4, FIFO address width; depth = 2**ADDR_W entries (16).

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  asynchronous, active-high reset
wr_en  input  1  host write strobe, one byte per cycle while high
wr_data  input  DBIT  host write byte
tx_en  input  1  launch enable; 0 holds off new launches, FIFO writes still accepted
tx_done_tick  input  1  one-cycle pulse from transmitter at end of stop bit
tx_start  output  1  one-cycle launch pulse to transmitter
tx_din  output  DBIT  byte to transmitter, stable from launch until tx_done_tick
full  output  1  count == 2**ADDR_W
empty  output  1  count == 0
count  output  ADDR_W+1  current occupancy, 0..2**ADDR_W
busy  output  1  1 when state != IDLE
overflow_tick  output  1  one-cycle pulse when wr_en is high while full

Behaviour:
- Reset (async, active-high): state=IDLE, rd/wr pointers=0, count=0, tx_start=0, tx_din=0, busy=0, overflow_tick=0, empty=1, full=0. FIFO contents discarded; a launch in progress is abandoned (transmitter reset separately).
- FIFO: wr_en && !full -> write wr_data at wr_ptr, wr_ptr+1 mod depth. Pop only by FSM (see LAUNCH). Pointers ADDR_W bits, natural wrap. count: +1 on accepted write, -1 on pop, unchanged when both occur in the same cycle.
- wr_en while full: write rejected even if a pop occurs the same cycle; data dropped; overflow_tick=1 next cycle (registered), count unchanged by the write.
- full/empty combinational from registered count.
- FSM states: IDLE, LAUNCH, WAIT.
  - IDLE: if !empty && tx_en -> tx_din <= FIFO[rd_ptr], state <= LAUNCH. Else stay.
  - LAUNCH (exactly one cycle): tx_start=1 (Moore output from state register); pop: rd_ptr+1, count-1. state <= WAIT.
  - WAIT: tx_start=0; tx_din held. On tx_done_tick -> IDLE. Else stay.
- Latency: write into empty FIFO in cycle N (tx_en=1) -> IDLE sees !empty at N+1 -> tx_start high at N+2.
- Back-to-back: tx_done_tick in cycle M with FIFO non-empty -> IDLE at M+1 -> tx_start at M+2. Minimum gap between tx_start pulses is 3 cycles plus the frame time.
- tx_done_tick in IDLE or LAUNCH: ignored.
- tx_en deasserted in LAUNCH/WAIT: current byte completes normally; only the next IDLE->LAUNCH decision is gated.
- tx_din changes only on the IDLE->LAUNCH transition and on reset.
- busy = (state != IDLE).

Test Plan:
- Reset, write 0xA5 once (tx_en=1) -> tx_start pulse exactly 2 cycles after write with tx_din=0xA5; count 1->0 in LAUNCH; busy=1 until the cycle after tx_done_tick.
- Write 0x11,0x22,0x33 back-to-back, model tx_done_tick 50 cycles after each tx_start -> three tx_start pulses carrying 0x11,0x22,0x33 in order, each 2 cycles after the previous tx_done_tick.
- With tx_en=0, write 17 bytes 0x00..0x10 -> full=1 and count=16 after the 16th; the 17th write produces overflow_tick=1 for one cycle; set tx_en=1 -> bytes 0x00..0x0F are transmitted, 0x10 never appears.
- While full and in LAUNCH (pop cycle), assert wr_en with 0xEE -> write rejected, overflow_tick pulses, count goes 16->15.
- Fill past wrap (write 20 and drain 20 interleaved) -> output order preserved across pointer wrap; empty=1 and count=0 at end.
- Assert reset mid-WAIT with 5 bytes queued -> all outputs return to reset values immediately; no tx_start after release until a new write.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//
// Byte buffer and launch controller placed directly in front of the UART
// transmitter. Host bytes are queued in a circular FIFO. A small controller
// hands them to the transmitter one at a time. Each byte is launched with a
// single-cycle tx_start pulse. The controller then waits for tx_done_tick
// before it considers the next byte. This lets the host write in bursts
// regardless of the serial line rate.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   reset          asynchronous, active-high reset
//   wr_en          host write strobe, one byte per cycle while high
//   wr_data        host write byte (DBIT bits)
//   tx_en          launch enable; low holds off new launches, writes still accepted
//   tx_done_tick   one-cycle pulse from the transmitter at the end of the stop bit
//   tx_start       one-cycle launch pulse to the transmitter
//   tx_din         byte to the transmitter, stable from launch until tx_done_tick
//   full           FIFO holds 2**ADDR_W bytes
//   empty          FIFO holds no bytes
//   count          current FIFO occupancy, 0..2**ADDR_W
//   busy           controller is launching or waiting on the transmitter
//   overflow_tick  one-cycle pulse the cycle after a write was attempted while full

module uart_tx_feeder #(
  parameter int DBIT   = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DBIT-1:0]   wr_data,
  input  logic              tx_en,
  input  logic              tx_done_tick,
  output logic              tx_start,
  output logic [DBIT-1:0]   tx_din,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              overflow_tick
);

  localparam int              DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT
  } state_t;

  state_t            state_reg;
  state_t            state_next;

  logic [DBIT-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  logic              wr_accept;
  logic              pop;
  logic              load_din;

  // Status flags come straight from the registered occupancy count, so they
  // never glitch on same-cycle write/pop activity.
  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  // A write attempted while full is dropped, even when a pop happens in the
  // same cycle; the slot freed by that pop only becomes usable next cycle.
  assign wr_accept = wr_en && !full;

  // The only place bytes leave the FIFO is the single LAUNCH cycle.
  assign pop = (state_reg == LAUNCH);

  // Launch pulse and busy are pure Moore outputs of the state register.
  assign tx_start = (state_reg == LAUNCH);
  assign busy     = (state_reg != IDLE);

  // Storage array has no reset: its contents are meaningless once the
  // pointers and count are cleared, so only accepted writes touch it.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Write pointer advances on every accepted byte and wraps naturally at
  // the FIFO depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (wr_accept) begin
      wr_ptr <= wr_ptr + ADDR_W'(1);
    end
  end

  // Read pointer advances once per launch, when the byte already copied to
  // tx_din is retired from the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + ADDR_W'(1);
    end
  end

  // Occupancy tracks accepted writes against pops; a write and a pop in the
  // same cycle cancel out. A pop can never underflow because LAUNCH is only
  // entered with a non-empty FIFO and nothing else removes bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      unique case ({wr_accept, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Overflow indication is registered, so it shows up the cycle after the
  // rejected write and lasts exactly one cycle per rejected write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_tick <= 1'b0;
    end else begin
      overflow_tick <= wr_en && full;
    end
  end

  // The outgoing byte is captured on the IDLE->LAUNCH decision and then held
  // untouched through LAUNCH and WAIT, so the transmitter sees a stable
  // value for the whole frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_din <= '0;
    end else if (load_din) begin
      tx_din <= mem[rd_ptr];
    end
  end

  // State register for the launch controller. Reset abandons any launch in
  // progress; the transmitter has its own reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. tx_en only gates the IDLE->LAUNCH decision, so a byte
  // already launched always runs to completion. tx_done_tick is only
  // meaningful in WAIT; stray ticks in IDLE or LAUNCH fall through the
  // defaults and are ignored.
  always_comb begin
    state_next = state_reg;
    load_din   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!empty && tx_en) begin
          load_din   = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (tx_done_tick) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder
//
// Directed bench for uart_tx_feeder. A single linear stimulus sequence
// drives host writes and stands in for the transmitter by pulsing
// tx_done_tick a fixed number of cycles after each launch. Inputs change
// and outputs are sampled 1 ns after each rising clock edge.

module tb_uart_tx_feeder;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx_en;
  logic       tx_done_tick;
  logic       tx_start;
  logic [7:0] tx_din;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       busy;
  logic       overflow_tick;

  int vectors;
  int miscompares;

  uart_tx_feeder #(
    .DBIT   (8),
    .ADDR_W (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .tx_en         (tx_en),
    .tx_done_tick  (tx_done_tick),
    .tx_start      (tx_start),
    .tx_din        (tx_din),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .busy          (busy),
    .overflow_tick (overflow_tick)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One comparison point: counts the vector and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one host byte for exactly one clock edge.
  task automatic applyStimulus(input logic [7:0] data);
    wr_en   = 1'b1;
    wr_data = data;
    step();
    wr_en   = 1'b0;
  endtask

  // Transmitter stand-in: one-cycle end-of-frame tick.
  task automatic pulseDone();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
  endtask

  // Called right after the tx_done_tick edge: the controller must be idle
  // for one cycle, then launch the next byte with a one-cycle pulse.
  task automatic relaunchCheck(input logic [7:0] nxt, input string tag);
    checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_idle_start"}, 32'(tx_start), 32'd0);
    step();
    checkOutput({tag, "_start"}, 32'(tx_start), 32'd1);
    checkOutput({tag, "_din"}, 32'(tx_din), 32'(nxt));
    step();
    checkOutput({tag, "_start_drop"}, 32'(tx_start), 32'd0);
    checkOutput({tag, "_wait_busy"}, 32'(busy), 32'd1);
  endtask

  initial begin
    int         next_wr;
    int         launches;
    logic [7:0] b;

    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b1;
    wr_en        = 1'b0;
    wr_data      = 8'h00;
    tx_en        = 1'b0;
    tx_done_tick = 1'b0;

    // ---------------- reset values ----------------
    step();
    step();
    checkOutput("rst_tx_start", 32'(tx_start), 32'd0);
    checkOutput("rst_tx_din", 32'(tx_din), 32'h00);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ovf", 32'(overflow_tick), 32'd0);
    reset = 1'b0;
    step();

    // ---------------- single byte latency ----------------
    tx_en = 1'b1;
    applyStimulus(8'hA5);
    checkOutput("t1_count_after_wr", 32'(count), 32'd1);
    checkOutput("t1_no_start_yet", 32'(tx_start), 32'd0);
    checkOutput("t1_idle", 32'(busy), 32'd0);
    step();
    checkOutput("t1_start", 32'(tx_start), 32'd1);
    checkOutput("t1_din", 32'(tx_din), 32'hA5);
    checkOutput("t1_busy_launch", 32'(busy), 32'd1);
    checkOutput("t1_count_launch", 32'(count), 32'd1);
    step();
    checkOutput("t1_start_drop", 32'(tx_start), 32'd0);
    checkOutput("t1_count_popped", 32'(count), 32'd0);
    checkOutput("t1_busy_wait", 32'(busy), 32'd1);
    repeat (3) step();
    checkOutput("t1_din_held", 32'(tx_din), 32'hA5);
    checkOutput("t1_busy_held", 32'(busy), 32'd1);
    pulseDone();
    checkOutput("t1_busy_done", 32'(busy), 32'd0);
    checkOutput("t1_empty_done", 32'(empty), 32'd1);

    // ---------------- three bytes back to back ----------------
    applyStimulus(8'h11);
    checkOutput("t2_count1", 32'(count), 32'd1);
    applyStimulus(8'h22);
    checkOutput("t2_start11", 32'(tx_start), 32'd1);
    checkOutput("t2_din11", 32'(tx_din), 32'h11);
    applyStimulus(8'h33);
    checkOutput("t2_start11_drop", 32'(tx_start), 32'd0);
    checkOutput("t2_count2", 32'(count), 32'd2);
    repeat (47) step();
    pulseDone();
    relaunchCheck(8'h22, "t2_b22");
    repeat (47) step();
    pulseDone();
    relaunchCheck(8'h33, "t2_b33");
    repeat (47) step();
    pulseDone();
    checkOutput("t2_idle_end", 32'(busy), 32'd0);
    checkOutput("t2_empty_end", 32'(empty), 32'd1);
    step();
    checkOutput("t2_no_extra_start", 32'(tx_start), 32'd0);

    // ---------------- fill, overflow, drain ----------------
    tx_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(8'(i));
    end
    checkOutput("t3_full", 32'(full), 32'd1);
    checkOutput("t3_count16", 32'(count), 32'd16);
    checkOutput("t3_no_ovf_yet", 32'(overflow_tick), 32'd0);
    checkOutput("t3_held_off", 32'(busy), 32'd0);
    applyStimulus(8'h10);
    checkOutput("t3_ovf", 32'(overflow_tick), 32'd1);
    checkOutput("t3_count_still16", 32'(count), 32'd16);
    step();
    checkOutput("t3_ovf_one_cycle", 32'(overflow_tick), 32'd0);
    tx_en = 1'b1;
    step();
    checkOutput("t3_start00", 32'(tx_start), 32'd1);
    checkOutput("t3_din00", 32'(tx_din), 32'h00);
    checkOutput("t3_full_launch", 32'(full), 32'd1);
    // Write during the pop cycle while still full: must be rejected.
    applyStimulus(8'hEE);
    checkOutput("t4_ovf_pop", 32'(overflow_tick), 32'd1);
    checkOutput("t4_count15", 32'(count), 32'd15);
    checkOutput("t4_not_full", 32'(full), 32'd0);
    step();
    checkOutput("t4_ovf_drop", 32'(overflow_tick), 32'd0);
    for (int i = 1; i < 16; i++) begin
      repeat (3) step();
      pulseDone();
      b = 8'(i);
      relaunchCheck(b, $sformatf("t3_b%02h", b));
    end
    repeat (3) step();
    pulseDone();
    step();
    step();
    checkOutput("t3_no_0x10", 32'(tx_start), 32'd0);
    checkOutput("t3_empty_end", 32'(empty), 32'd1);
    checkOutput("t3_count_end", 32'(count), 32'd0);

    // ---------------- pointer wrap with interleaved writes ----------------
    next_wr = 1;
    applyStimulus(8'h40);
    step();
    checkOutput("t5_start40", 32'(tx_start), 32'd1);
    checkOutput("t5_din40", 32'(tx_din), 32'h40);
    for (int k = 1; k < 20; k++) begin
      for (int j = 0; j < 6; j++) begin
        if (j < 2 && next_wr < 20) begin
          wr_en   = 1'b1;
          wr_data = 8'(8'h40 + next_wr);
          next_wr++;
        end else begin
          wr_en = 1'b0;
        end
        step();
      end
      wr_en = 1'b0;
      pulseDone();
      b = 8'(8'h40 + k);
      relaunchCheck(b, $sformatf("t5_b%02h", b));
    end
    repeat (3) step();
    pulseDone();
    step();
    checkOutput("t5_empty_end", 32'(empty), 32'd1);
    checkOutput("t5_count_end", 32'(count), 32'd0);
    checkOutput("t5_idle_end", 32'(busy), 32'd0);
    checkOutput("t5_no_start_end", 32'(tx_start), 32'd0);

    // ---------------- asynchronous reset mid-WAIT ----------------
    for (int i = 0; i < 6; i++) begin
      applyStimulus(8'(8'h60 + i));
    end
    step();
    checkOutput("t6_count5", 32'(count), 32'd5);
    checkOutput("t6_busy_wait", 32'(busy), 32'd1);
    checkOutput("t6_din60", 32'(tx_din), 32'h60);
    reset = 1'b1;
    #1;
    checkOutput("t6_async_count", 32'(count), 32'd0);
    checkOutput("t6_async_busy", 32'(busy), 32'd0);
    checkOutput("t6_async_din", 32'(tx_din), 32'h00);
    checkOutput("t6_async_empty", 32'(empty), 32'd1);
    checkOutput("t6_async_full", 32'(full), 32'd0);
    checkOutput("t6_async_start", 32'(tx_start), 32'd0);
    checkOutput("t6_async_ovf", 32'(overflow_tick), 32'd0);
    step();
    step();
    reset    = 1'b0;
    launches = 0;
    repeat (10) begin
      step();
      if (tx_start) launches++;
    end
    checkOutput("t6_no_spurious_start", 32'(launches), 32'd0);
    checkOutput("t6_still_empty", 32'(empty), 32'd1);
    applyStimulus(8'h77);
    step();
    checkOutput("t6_start77", 32'(tx_start), 32'd1);
    checkOutput("t6_din77", 32'(tx_din), 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
